// File: rtl/bus_requester.sv
// bus_requester
//   Queues write beats in a small FIFO and, on a burst command, asks a
//   round-robin arbiter for the bus. Once granted, it streams the FIFO out
//   one beat per granted cycle until the burst length is reached.
//
// Handshakes:
//   A command transfers on a rising edge where cmd_valid & cmd_ready. A beat
//   enters the FIFO on a rising edge where din_valid & din_ready. cmd_valid
//   and din_valid must be held, with their payloads stable, until the
//   transfer. bus_valid has no back-pressure: every bus_valid cycle is one
//   beat consumed by the bus.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   cmd_valid/ready    burst command handshake, cmd_len = beats - 1
//   din_valid/ready    write-beat push into the FIFO, din = beat data
//   req                request to the arbiter (registered)
//   gnt                registered grant from the arbiter
//   bus_valid          a beat is on the bus this cycle, bus_data = FIFO head
//   done               one-cycle pulse on the last beat of a burst
//   err                one-cycle pulse on grant timeout or grant loss
//   dbg_state          current FSM state (0 IDLE, 1 REQ, 2 XFER, 3 RELEASE)
//   dbg_count          current FIFO occupancy
module bus_requester #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,   // power of two, at least 2
  parameter int TIMEOUT    = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd_len,
  input  logic                        din_valid,
  output logic                        din_ready,
  input  logic [DATA_W-1:0]           din,
  output logic                        req,
  input  logic                        gnt,
  output logic                        bus_valid,
  output logic [DATA_W-1:0]           bus_data,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_req;
  logic [3:0]          r_len;
  logic [3:0]          r_beat;
  logic [WAIT_W-1:0]   r_wait;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_cmd_ready;
  logic                w_bus_valid;
  logic                w_done;
  logic                w_err;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  // No bypass: a full FIFO refuses a push even in a cycle that pops.
  assign w_push  = din_valid & ~w_full;
  assign w_pop   = bus_valid;

  // Next-state and combinational outputs.
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_bus_valid = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_REQ;
      end
      S_REQ: begin
        if (gnt) begin
          w_next = S_XFER;
        end else if (r_wait == WAIT_LAST) begin
          w_err  = 1'b1;
          w_next = S_RELEASE;
        end
      end
      S_XFER: begin
        if (!gnt) begin
          // Grant lost mid-burst: abandon, leave unsent beats queued.
          w_err  = 1'b1;
          w_next = S_RELEASE;
        end else if (!w_empty) begin
          w_bus_valid = 1'b1;
          if (r_beat == r_len) begin
            w_done = 1'b1;
            w_next = S_RELEASE;
          end
        end
        // gnt & empty: underrun stall, req stays high.
      end
      S_RELEASE: begin
        // One cycle with req low so the arbiter rotates; gnt ignored.
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pulses are suppressed while reset is asserted so a mid-burst reset
  // never reports a completion or an error.
  assign cmd_ready = w_cmd_ready;
  assign bus_valid = w_bus_valid & ~reset;
  assign done      = w_done & ~reset;
  assign err       = w_err & ~reset;
  assign req       = r_req;
  assign din_ready = ~w_full;
  assign bus_data  = r_mem[r_rd_ptr];
  assign dbg_state = r_state;
  assign dbg_count = r_count;

  // FSM state, request flop and burst counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_len   <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      // req is decoded from the next state into a flop, so it equals
      // (state == REQ || state == XFER) with no path from any input.
      r_req   <= (w_next == S_REQ) || (w_next == S_XFER);

      if (r_state == S_IDLE && cmd_valid) begin
        r_len  <= cmd_len;
        r_beat <= '0;
      end else if (w_pop) begin
        r_beat <= r_beat + 4'd1;
      end

      if (r_state == S_REQ && !gnt) r_wait <= r_wait + 1'b1;
      else                          r_wait <= '0;
    end
  end

  // FIFO storage is not reset; only pointers and count are.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_requester.sv
// tb_bus_requester
//   Directed bench for bus_requester with default parameters (DATA_W 8,
//   FIFO_DEPTH 8, TIMEOUT 64). The grant is modelled as a registered echo
//   of req, gated by gnt_en, which also produces the stale grant seen one
//   cycle after req falls.
module tb_bus_requester;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_len = 4'd0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] din = 8'd0;
  logic       req;
  logic       gnt;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;
  logic [3:0] dbg_count;

  logic       gnt_auto = 1'b0;
  logic       gnt_en = 1'b0;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [7:0] beat_q[$];
  int         beat_cyc_q[$];
  int         cyc_n = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         rel_cnt = 0;
  int         rise_cnt = 0;
  logic       req_prev = 1'b0;
  int         fullpop_seen = 0;
  int         fullpop_bad = 0;
  int         cnt_model = 0;
  int         cnt_bad = 0;
  logic       cnt_on = 1'b0;

  logic [7:0] t1_req;
  logic [7:0] t1_bv;
  logic [7:0] t1_done;
  logic [7:0] t1_rdy;

  bus_requester #(.DATA_W(8), .FIFO_DEPTH(8), .TIMEOUT(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .req       (req),
    .gnt       (gnt),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------- clock / reset / arbiter model ----------------
  always #5 clock = ~clock;

  always @(posedge clock) gnt_auto <= req;
  assign gnt = gnt_en & gnt_auto;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor (samples on falling edge) ----------------
  initial begin
    forever begin
      @(negedge clock);
      cyc_n++;
      if (!reset) begin
        if (bus_valid) begin
          beat_q.push_back(bus_data);
          beat_cyc_q.push_back(cyc_n);
          if (dbg_count == 4'd8) begin
            fullpop_seen++;
            if (din_ready) fullpop_bad++;
          end
        end
        if (dbg_state == 2'd3) rel_cnt++;
        if (req && !req_prev) rise_cnt++;
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
      req_prev = req;
      if (cnt_on && (int'(dbg_count) != cnt_model)) cnt_bad++;
      if (reset) cnt_model = 0;
      else cnt_model = cnt_model + ((din_valid && din_ready) ? 1 : 0) - (bus_valid ? 1 : 0);
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_mon();
    beat_q.delete();
    beat_cyc_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    rel_cnt = 0;
    rise_cnt = 0;
    fullpop_seen = 0;
    fullpop_bad = 0;
    cnt_bad = 0;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    din = d;
    din_valid = 1'b1;
    @(negedge clock);
    while (!din_ready && n < 300) begin
      cyc();
      @(negedge clock);
      n++;
    end
    check("push_ready", din_ready, 1);
    cyc();
    din_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] len);
    int n;
    n = 0;
    cmd_len = len;
    cmd_valid = 1'b1;
    @(negedge clock);
    while (!cmd_ready && n < 300) begin
      cyc();
      @(negedge clock);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_beats(input int k);
    int n;
    n = 0;
    while (beat_q.size() < k && n < 300) begin
      cyc();
      n++;
    end
    check("beat_wait", beat_q.size() >= k, 1);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && err_cnt == 0 && n < 500) begin
      cyc();
      n++;
    end
    check("done_wait", done_cnt >= target, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int n_req;
    logic got_err;

    // Reset state
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clock);
    check("rst_req", req, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_din_ready", din_ready, 1);
    check("rst_count", dbg_count, 0);
    check("rst_state", dbg_state, 0);
    cyc();

    // Single 4-beat burst, grant one cycle after req, cycle exact
    gnt_en = 1'b1;
    clr_mon();
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    @(negedge clock);
    check("b1_count", dbg_count, 4);
    cyc();
    t1_req  = 8'b0011_1111;
    t1_bv   = 8'b0011_1100;
    t1_done = 8'b0010_0000;
    t1_rdy  = 8'b1000_0000;
    send_cmd(4'd3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("b1_req", req, t1_req[i]);
      check("b1_bus_valid", bus_valid, t1_bv[i]);
      check("b1_done", done, t1_done[i]);
      check("b1_err", err, 0);
      check("b1_cmd_ready", cmd_ready, t1_rdy[i]);
      if (t1_bv[i]) check("b1_data", bus_data, 32'(8'hA0 + i - 2));
      if (i == 6) check("b1_release_state", dbg_state, 3);
      if (i == 7) check("b1_idle_state", dbg_state, 0);
      cyc();
    end
    check("b1_count_after", dbg_count, 0);

    // Underrun: one beat queued, the rest pushed later
    clr_mon();
    push(8'hB0);
    send_cmd(4'd2);
    wait_beats(1);
    repeat (5) cyc();
    @(negedge clock);
    check("ur_stall_req", req, 1);
    check("ur_stall_bv", bus_valid, 0);
    check("ur_stall_state", dbg_state, 2);
    cyc();
    push(8'hB1);
    push(8'hB2);
    wait_done(1);
    repeat (3) cyc();
    check("ur_beats", beat_q.size(), 3);
    for (int i = 0; i < beat_q.size() && i < 3; i++)
      check("ur_data", beat_q[i], 32'(8'hB0 + i));
    if (beat_cyc_q.size() >= 2)
      check("ur_gap", (beat_cyc_q[1] - beat_cyc_q[0]) >= 6, 1);
    check("ur_done_cnt", done_cnt, 1);
    check("ur_err_cnt", err_cnt, 0);
    check("ur_req_rises", rise_cnt, 1);
    check("ur_release_cycles", rel_cnt, 1);

    // Grant timeout with two beats queued
    gnt_en = 1'b0;
    clr_mon();
    push(8'hC0);
    push(8'hC1);
    send_cmd(4'd0);
    n = 0;
    n_req = 0;
    got_err = 1'b0;
    while (!got_err && n < 200) begin
      @(negedge clock);
      if (req) n_req++;
      if (err) got_err = 1'b1;
      else cyc();
      n++;
    end
    check("to_err_seen", got_err, 1);
    check("to_req_cycles", n_req, 64);
    check("to_done_at_err", done, 0);
    cyc();
    @(negedge clock);
    check("to_req_low", req, 0);
    check("to_err_once", err, 0);
    check("to_release", dbg_state, 3);
    cyc();
    @(negedge clock);
    check("to_idle", dbg_state, 0);
    check("to_count_kept", dbg_count, 2);
    check("to_err_cnt", err_cnt, 1);
    check("to_done_cnt", done_cnt, 0);
    cyc();

    // Grant loss after beat 2 of an 8-beat burst
    clr_mon();
    for (int i = 2; i < 8; i++) push(8'(8'hC0 + i));
    gnt_en = 1'b1;
    send_cmd(4'd7);
    n = 0;
    while (beat_q.size() < 2 && n < 100) begin
      cyc();
      n++;
    end
    gnt_en = 1'b0;
    @(negedge clock);
    check("gl_err", err, 1);
    check("gl_bv", bus_valid, 0);
    check("gl_done", done, 0);
    cyc();
    @(negedge clock);
    check("gl_req_low", req, 0);
    check("gl_release", dbg_state, 3);
    cyc();
    @(negedge clock);
    check("gl_idle_ready", cmd_ready, 1);
    check("gl_beats", beat_q.size(), 2);
    for (int i = 0; i < beat_q.size() && i < 2; i++)
      check("gl_data", beat_q[i], 32'(8'hC0 + i));
    check("gl_remaining", dbg_count, 6);
    check("gl_done_cnt", done_cnt, 0);
    check("gl_err_cnt", err_cnt, 1);
    check("gl_release_cycles", rel_cnt, 1);
    cyc();

    // Reset in the middle of a transfer, after 3 beats
    clr_mon();
    gnt_en = 1'b1;
    send_cmd(4'd7);
    n = 0;
    while (beat_q.size() < 3 && n < 100) begin
      cyc();
      n++;
    end
    reset = 1'b1;
    @(negedge clock);
    check("mr_bv_in_reset", bus_valid, 0);
    check("mr_done_in_reset", done, 0);
    check("mr_err_in_reset", err, 0);
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("mr_req", req, 0);
    check("mr_bv", bus_valid, 0);
    check("mr_count", dbg_count, 0);
    check("mr_din_ready", din_ready, 1);
    check("mr_state", dbg_state, 0);
    check("mr_beats", beat_q.size(), 3);
    check("mr_done_cnt", done_cnt, 0);
    check("mr_err_cnt", err_cnt, 0);
    cyc();

    // Fill the FIFO, then 3 back-to-back 8-beat bursts while streaming
    clr_mon();
    cnt_on = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    @(negedge clock);
    check("ff_full_ready", din_ready, 0);
    check("ff_full_count", dbg_count, 8);
    cyc();
    din = 8'hEE;
    din_valid = 1'b1;
    repeat (2) cyc();
    din_valid = 1'b0;
    @(negedge clock);
    check("ff_no_overflow", dbg_count, 8);
    cyc();
    fork
      begin
        for (int i = 8; i < 24; i++) push(8'(8'h10 + i));
      end
      begin
        for (int b = 0; b < 3; b++) begin
          send_cmd(4'd7);
          wait_done(b + 1);
        end
      end
    join
    repeat (4) cyc();
    cnt_on = 1'b0;
    check("ff_beats", beat_q.size(), 24);
    for (int i = 0; i < beat_q.size() && i < 24; i++)
      check("ff_order", beat_q[i], 32'(8'h10 + i));
    check("ff_done_cnt", done_cnt, 3);
    check("ff_err_cnt", err_cnt, 0);
    check("ff_release_cycles", rel_cnt, 3);
    check("ff_req_rises", rise_cnt, 3);
    check("ff_full_pop_seen", fullpop_seen > 0, 1);
    check("ff_full_pop_no_bypass", fullpop_bad, 0);
    check("ff_count_track", cnt_bad, 0);
    @(negedge clock);
    check("ff_final_count", dbg_count, 0);
    check("ff_final_state", dbg_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_requester.md
BUS_REQUESTER -- requirements
Module: bus_requester

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 8, bus beat width in bits.
- FIFO_DEPTH, 8, beat FIFO entries (power of two).
- TIMEOUT, 64, maximum cycles to wait for grant.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high reset.
- cmd_valid, in, 1, burst command offered.
- cmd_ready, out, 1, command accepted when cmd_valid & cmd_ready.
- cmd_len, in, 4, beats minus one (0 = 1 beat, 15 = 16 beats).
- din_valid, in, 1, write beat offered to the FIFO.
- din_ready, out, 1, FIFO not full.
- din, in, DATA_W, beat data.
- req, out, 1, request to the round-robin arbiter.
- gnt, in, 1, registered grant from the arbiter for this port.
- bus_valid, out, 1, beat driven on the bus this cycle.
- bus_data, out, DATA_W, FIFO head data.
- done, out, 1, one-cycle pulse when a burst completes.
- err, out, 1, one-cycle pulse on grant timeout or grant loss.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, XFER and RELEASE.
REQ-004 cmd_ready SHALL be 1 only in IDLE; on acceptance, len SHALL latch, the beat counter SHALL clear, and the next state SHALL be REQ.
REQ-005 req SHALL be 1 exactly when the state is REQ or XFER (a registered decode, with no combinational path from any input).
REQ-006 In REQ, the wait counter SHALL increment each cycle with gnt=0.
REQ-007 In REQ, gnt=1 at a rising edge SHALL move the FSM to XFER and clear the wait counter.
REQ-008 In REQ, if the wait counter reaches TIMEOUT-1 with gnt=0, the block SHALL pulse err and go to RELEASE, with done not asserted.
REQ-009 In XFER, bus_valid SHALL equal gnt & FIFO-not-empty (combinational).
REQ-010 Each bus_valid cycle SHALL pop one entry and increment the beat counter.
REQ-011 When the FIFO is empty in XFER, the block SHALL stall with bus_valid=0 and req held, for unbounded duration.
REQ-012 On the beat where the beat counter equals len, the block SHALL pulse done in that same cycle and go to RELEASE, so req falls the following cycle.
REQ-013 If gnt=0 in XFER before the last beat, the block SHALL pulse err, go to RELEASE, and pop nothing that cycle, leaving unsent beats in the FIFO.
REQ-014 RELEASE SHALL last exactly one cycle with req=0 and bus_valid=0, then go to IDLE; this guarantees that the arbiter sees req low and rotates.
REQ-015 gnt SHALL be ignored in IDLE and RELEASE, including a stale grant held one cycle after req falls.
REQ-016 The FIFO SHALL accept a push when din_valid & din_ready in any state, with din_ready = count < FIFO_DEPTH.
REQ-017 A simultaneous push and pop SHALL leave count unchanged.
REQ-018 A full FIFO SHALL keep din_ready=0 even while popping (no bypass).
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-020 bus_data SHALL equal the FIFO head whenever the FIFO is not empty; its value when empty is don't-care.

Reset
REQ-021 While reset=1 at a rising edge: state=IDLE, and req, bus_valid, done and err SHALL be 0.
REQ-022 Reset SHALL empty the FIFO (pointers and count 0, din_ready=1) and clear all counters.
REQ-023 Reset mid-burst SHALL drop req on the next cycle, with no done or err pulse.

Verification
REQ-024 Single burst: push 4 beats 0xA0..0xA3, cmd_len=3, gnt one cycle after req -> bus_valid for 4 consecutive cycles with data A0..A3, done on the A3 cycle, req low for 1 cycle, then cmd_ready=1.
REQ-025 Underrun: cmd_len=2 with 1 beat queued, 2nd beat pushed 5 cycles later -> bus_valid gap of at least 5 cycles, req held throughout, 3 beats total, done once.
REQ-026 Timeout: TIMEOUT=64, gnt tied 0 -> err pulse 64 cycles after req rises, req low the next cycle, then IDLE, FIFO count unchanged.
REQ-027 Grant loss: gnt dropped after beat 2 of an 8-beat burst -> err pulse, no done, 6 beats remain, req low for 1 cycle.
REQ-028 FIFO full/wrap: push 8 beats (din_ready goes 0), run 3 back-to-back 8-beat bursts while streaming 16 more beats -> 24 beats delivered in order, no loss, req low 1 cycle between bursts.
REQ-029 Reset mid-XFER after 3 beats -> req=0, bus_valid=0, count=0, din_ready=1 on the first post-reset cycle.
